// File: rtl/uart_tx_peripheral_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, MEM-stage access lengths and transmitter state encodings.
package uart_tx_peripheral_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_BAUD   = 4'h8;
  localparam logic [3:0] UART_RSVD   = 4'hC;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic [2:0] LEN_BYTE = 3'b000;
  localparam logic [2:0] LEN_HALF = 3'b001;
  localparam logic [2:0] LEN_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // A divider below 2 cannot time a bit, so it is clamped on the way in.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/uart_tx_peripheral_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and first-word-fall-through read data.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: register window decode, TX FIFO and bit serialiser.
//   state  | meaning
//   IDLE   | line high, waiting for FIFO data
//   START  | start bit (low) for one bit period
//   DATA   | eight data bits, LSB first
//   STOP   | stop bit (high); back-to-back frames restart from here
module uart_tx_peripheral
  import uart_tx_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          DEFAULT_DIV = 469
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  mem_op_length,
  output logic        selected,
  output logic [31:0] output_data,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_t     r_state, w_state_nxt;
  logic          r_tx, w_tx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [15:0]   r_div, w_div_nxt;
  logic [15:0]   r_baud;
  logic          r_ovf;
  logic          r_irq;

  logic [3:0]    w_off;
  logic          w_wr_txdata, w_wr_status, w_wr_baud;
  logic          w_pop, w_full, w_empty, w_tc;
  logic [7:0]    w_rdata;
  logic [CW-1:0] w_count;
  logic          w_unused;

  assign selected    = (address >= BASE_ADDR) && (address <= BASE_ADDR + 32'hC);
  assign w_off       = {address[3:2], 2'b00};
  assign w_wr_txdata = mem_write & selected & (w_off == UART_TXDATA);
  assign w_wr_status = mem_write & selected & (w_off == UART_STATUS);
  assign w_wr_baud   = mem_write & selected & (w_off == UART_BAUD) & (mem_op_length == LEN_WORD);
  assign w_tc        = (r_cnt == 16'd0);
  assign w_unused    = &{1'b0, input_data[31:16]};
  assign tx          = r_tx;
  assign irq         = r_irq;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_wr_txdata),
    .pop   (w_pop),
    .wdata (input_data[7:0]),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    output_data = '0;
    if (selected && mem_read) begin
      case (w_off)
        UART_STATUS: begin
          output_data[STAT_BUSY]                = (r_state != ST_IDLE);
          output_data[STAT_FULL]                = w_full;
          output_data[STAT_EMPTY]               = w_empty;
          output_data[STAT_OVF]                 = r_ovf;
          output_data[STAT_COUNT_LSB +: CW]     = w_count;
        end
        UART_BAUD: output_data[15:0] = r_baud;
        default:   output_data = '0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rdata;
          w_div_nxt   = r_baud;
          w_cnt_nxt   = r_baud - 16'd1;
          w_tx_nxt    = 1'b0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tc) begin
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = 3'd0;
          w_cnt_nxt   = r_div - 16'd1;
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (w_tc) begin
          w_cnt_nxt = r_div - 16'd1;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (w_tc) begin
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_rdata;
            w_div_nxt   = r_baud;
            w_cnt_nxt   = r_baud - 16'd1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_div   <= 16'(DEFAULT_DIV);
      r_baud  <= 16'(DEFAULT_DIV);
      r_ovf   <= 1'b0;
      r_irq   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_irq   <= w_empty & (r_state == ST_IDLE);
      if (w_wr_baud) r_baud <= clamp_div(input_data[15:0]);
      if (w_wr_txdata && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr_status && input_data[STAT_OVF]) r_ovf <= 1'b0;
    end
  end

endmodule
